// File: rtl/filter_verdict_ctrl.sv
// Verdict sequencer: pairs queued pass/drop verdicts with whole packets, forwarding or draining each.
// Optional pass byte accumulator enabled by FILTER_VERDICT_BYTE_COUNT_EN.
module filter_verdict_ctrl #(
   parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned VERDICT_DEPTH_BITS = 4,
   parameter int unsigned NEARLY_FULL_SLACK  = 2
) (
   input  logic                            axi_aclk,
   input  logic                            axi_areset,
   input  logic                            result_wr_en,
   input  logic                            result_din,
   output logic                            result_nearly_full,
   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   input  logic                            clear_counters,
   output logic [31:0]                     pass_count,
   output logic [31:0]                     drop_count,
   output logic                            verdict_overflow
`ifdef FILTER_VERDICT_BYTE_COUNT_EN
   ,
   output logic [31:0]                     pass_byte_count
`endif
);

   localparam int unsigned STRB_W = C_AXIS_DATA_WIDTH / 8;
   localparam int unsigned DEPTH  = 1 << VERDICT_DEPTH_BITS;
   localparam int unsigned CNT_W  = VERDICT_DEPTH_BITS + 1;

   typedef enum logic [1:0] {ST_WAIT, ST_PASS, ST_DROP} state_t;

   state_t                        state;
   logic [DEPTH-1:0]              verdict_mem;
   logic [VERDICT_DEPTH_BITS-1:0] rd_ptr;
   logic [VERDICT_DEPTH_BITS-1:0] wr_ptr;
   logic [CNT_W-1:0]              count;
   logic [CNT_W-1:0]              count_next;
   logic                          fifo_empty;
   logic                          fifo_full;
   logic                          pop;
   logic                          push;
   logic                          lost;
   logic                          pass_done;
   logic                          drop_done;

   // Stream passthrough; data is only qualified by m_axis_tvalid in PASS
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tstrb  = s_axis_tstrb;
   assign m_axis_tuser  = s_axis_tuser;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tvalid = (state == ST_PASS) && s_axis_tvalid;
   assign s_axis_tready = (state == ST_PASS) ? m_axis_tready : (state == ST_DROP);

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(DEPTH));
   assign pop        = (state == ST_WAIT) && !fifo_empty && s_axis_tvalid;
   // A same-cycle pop frees the slot before the push is considered
   assign push       = result_wr_en && (!fifo_full || pop);
   assign lost       = result_wr_en && fifo_full && !pop;
   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   assign pass_done = (state == ST_PASS) && s_axis_tvalid && m_axis_tready && s_axis_tlast;
   assign drop_done = (state == ST_DROP) && s_axis_tvalid && s_axis_tlast;

   always_ff @(posedge axi_aclk) begin
      if (push) verdict_mem[wr_ptr] <= result_din;
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state              <= ST_WAIT;
         rd_ptr             <= '0;
         wr_ptr             <= '0;
         count              <= '0;
         result_nearly_full <= 1'b0;
         pass_count         <= '0;
         drop_count         <= '0;
         verdict_overflow   <= 1'b0;
      end else begin
         case (state)
            ST_WAIT: if (pop) state <= verdict_mem[rd_ptr] ? ST_PASS : ST_DROP;
            ST_PASS: if (pass_done) state <= ST_WAIT;
            ST_DROP: if (drop_done) state <= ST_WAIT;
            default: state <= ST_WAIT;
         endcase

         if (pop)  rd_ptr <= rd_ptr + VERDICT_DEPTH_BITS'(1);
         if (push) wr_ptr <= wr_ptr + VERDICT_DEPTH_BITS'(1);
         count              <= count_next;
         result_nearly_full <= (CNT_W'(DEPTH) - count_next) <= CNT_W'(NEARLY_FULL_SLACK);

         if (clear_counters) begin
            pass_count       <= '0;
            drop_count       <= '0;
            verdict_overflow <= 1'b0;
         end else begin
            if (pass_done && pass_count != '1) pass_count <= pass_count + 32'd1;
            if (drop_done && drop_count != '1) drop_count <= drop_count + 32'd1;
            if (lost) verdict_overflow <= 1'b1;
         end
      end
   end

`ifdef FILTER_VERDICT_BYTE_COUNT_EN
   localparam int unsigned POP_W = $clog2(STRB_W + 1);

   logic [POP_W-1:0] strb_ones;
   logic [32:0]      byte_sum;
   logic             pass_beat;

   assign pass_beat = (state == ST_PASS) && s_axis_tvalid && m_axis_tready;

   always_comb begin
      strb_ones = '0;
      for (int i = 0; i < int'(STRB_W); i++) strb_ones = strb_ones + POP_W'(s_axis_tstrb[i]);
   end

   assign byte_sum = {1'b0, pass_byte_count} + 33'(strb_ones);

   // Saturating byte accumulator; clear beats a same-cycle add
   always_ff @(posedge axi_aclk) begin
      if (axi_areset || clear_counters) pass_byte_count <= '0;
      else if (pass_beat)               pass_byte_count <= byte_sum[32] ? '1 : byte_sum[31:0];
   end
`endif

endmodule

// File: tb/tb_filter_verdict_ctrl.sv
// Bench for filter_verdict_ctrl: queue-based reference model checked every cycle, plus directed literals.
module tb_filter_verdict_ctrl;

   logic         clk;
   logic         rst;
   logic         wr_en;
   logic         din;
   logic         nf;
   logic [255:0] s_tdata;
   logic [31:0]  s_tstrb;
   logic [127:0] s_tuser;
   logic         s_tvalid;
   logic         s_tready;
   logic         s_tlast;
   logic [255:0] m_tdata;
   logic [31:0]  m_tstrb;
   logic [127:0] m_tuser;
   logic         m_tvalid;
   logic         m_tready;
   logic         m_tlast;
   logic         clr;
   logic [31:0]  pc;
   logic [31:0]  dc;
   logic         ovf;
`ifdef FILTER_VERDICT_BYTE_COUNT_EN
   logic [31:0]  bc;
`endif

   filter_verdict_ctrl dut (
      .axi_aclk(clk), .axi_areset(rst),
      .result_wr_en(wr_en), .result_din(din), .result_nearly_full(nf),
      .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .clear_counters(clr), .pass_count(pc), .drop_count(dc), .verdict_overflow(ovf)
`ifdef FILTER_VERDICT_BYTE_COUNT_EN
      , .pass_byte_count(bc)
`endif
   );

   int total = 0;
   int bad   = 0;
   int outbeats = 0;
   bit started = 0;
   bit rdy_rand = 0;

   // reference model: mode 0 = awaiting packet, 1 = forwarding, 2 = draining
   int          mmode = 0;
   bit          mq[$];
   logic [31:0] mpc = 0, mdc = 0, mbc = 0;
   bit          movf = 0, mnf = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] sat_add(input logic [31:0] a, input int b);
      longint s;
      s = longint'(a) + longint'(b);
      return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   // model update from the inputs seen at this edge
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         mmode = 0; mpc = 0; mdc = 0; mbc = 0; movf = 0; mnf = 0;
      end else begin
         bit beat_ok, pdone, ddone, lostv;
         beat_ok = (mmode == 1) && s_tvalid && m_tready;
         pdone   = beat_ok && s_tlast;
         ddone   = (mmode == 2) && s_tvalid && s_tlast;
         if (mmode == 0 && mq.size() > 0 && s_tvalid) mmode = mq.pop_front() ? 1 : 2;
         else if (pdone || ddone) mmode = 0;
         lostv = 0;
         if (wr_en) begin
            if (mq.size() < 16) mq.push_back(din);
            else lostv = 1;
         end
         if (clr) begin
            mpc = 0; mdc = 0; mbc = 0; movf = 0;
         end else begin
            if (pdone) mpc = sat_add(mpc, 1);
            if (ddone) mdc = sat_add(mdc, 1);
            if (beat_ok) mbc = sat_add(mbc, $countones(s_tstrb));
            if (lostv) movf = 1;
         end
         mnf = (16 - mq.size()) <= 2;
      end
      started = 1;
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         bit exp_rdy, exp_vld;
         exp_rdy = (mmode == 1) ? m_tready : (mmode == 2);
         exp_vld = (mmode == 1) && s_tvalid;
         chk("s_tready", 256'(s_tready), 256'(exp_rdy));
         chk("m_tvalid", 256'(m_tvalid), 256'(exp_vld));
         chk("pass_count", 256'(pc), 256'(mpc));
         chk("drop_count", 256'(dc), 256'(mdc));
         chk("overflow", 256'(ovf), 256'(movf));
         chk("nearly_full", 256'(nf), 256'(mnf));
`ifdef FILTER_VERDICT_BYTE_COUNT_EN
         chk("byte_count", 256'(bc), 256'(mbc));
`endif
         if (exp_vld) begin
            chk("m_tdata", m_tdata, s_tdata);
            chk("m_tstrb", 256'(m_tstrb), 256'(s_tstrb));
            chk("m_tuser", 256'(m_tuser), 256'(s_tuser));
            chk("m_tlast", 256'(m_tlast), 256'(s_tlast));
         end
         if (m_tvalid && m_tready) outbeats++;
      end
   end

   always @(posedge clk) begin
      #1;
      m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic push(input bit v);
      wr_en = 1'b1;
      din   = v;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rand_beat(input bit last);
      for (int w = 0; w < 8; w++) s_tdata[w*32 +: 32] = $urandom();
      s_tstrb = $urandom();
      s_tuser = {$urandom(), $urandom(), $urandom(), $urandom()};
      s_tlast = last;
   endtask

   task automatic send_pkt(input int nb, input bit gaps, input bit clr_last);
      for (int b = 0; b < nb; b++) begin
         bit acc;
         int waitc;
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_tvalid = 1'b0;
            tick();
         end
         rand_beat(b == nb - 1);
         s_tvalid = 1'b1;
         clr = clr_last && (b == nb - 1);
         acc = 0;
         waitc = 0;
         while (!acc && waitc < 300) begin
            @(negedge clk);
            acc = s_tready;
            tick();
            clr = 1'b0;
            waitc++;
         end
         if (!acc) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: beat %0d never accepted, required acceptance within 300 cycles", b);
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   initial begin
      bit v[17];
      int ones;
      int ob0;
      rst = 1; wr_en = 0; din = 0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
      s_tvalid = 0; s_tlast = 0; m_tready = 1; clr = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // reset values
      chk("rst_tready", 256'(s_tready), 256'(0));
      chk("rst_tvalid", 256'(m_tvalid), 256'(0));
      chk("rst_nf", 256'(nf), 256'(0));
      chk("rst_pc", 256'(pc), 256'(0));
      chk("rst_dc", 256'(dc), 256'(0));
      chk("rst_ovf", 256'(ovf), 256'(0));

      // one 3-beat pass packet
      ob0 = outbeats;
      push(1);
      send_pkt(3, 0, 0);
      tick();
      chk("t1_pass", 256'(pc), 256'(1));
      chk("t1_beats", 256'(outbeats - ob0), 256'(3));

      // drop then pass
      ob0 = outbeats;
      push(0);
      push(1);
      send_pkt(2, 0, 0);
      send_pkt(1, 0, 0);
      tick();
      chk("t2_drop", 256'(dc), 256'(1));
      chk("t2_pass", 256'(pc), 256'(2));
      chk("t2_beats", 256'(outbeats - ob0), 256'(1));

      // packet waits on empty verdict FIFO
      rand_beat(1);
      s_tvalid = 1;
      repeat (10) begin
         @(negedge clk);
         chk("t3_stall", 256'(s_tready), 256'(0));
         tick();
      end
      wr_en = 1; din = 1;
      tick();
      wr_en = 0;
      @(negedge clk);
      chk("t3_n1_valid", 256'(m_tvalid), 256'(0));
      tick();
      @(negedge clk);
      chk("t3_n2_valid", 256'(m_tvalid), 256'(1));
      chk("t3_n2_ready", 256'(s_tready), 256'(1));
      tick();
      s_tvalid = 0; s_tlast = 0;
      tick();
      chk("t3_pass", 256'(pc), 256'(3));

      // fill past depth, nearly-full threshold and overflow
      for (int i = 0; i < 17; i++) begin
         v[i] = 1'($urandom_range(0, 1));
         push(v[i]);
         chk("t4_nf", 256'(nf), 256'(i + 1 >= 14));
      end
      chk("t4_ovf", 256'(ovf), 256'(1));
      clr = 1;
      tick();
      clr = 0;
      chk("t4_clr_ovf", 256'(ovf), 256'(0));
      chk("t4_clr_pc", 256'(pc), 256'(0));
      // pop and push together while full
      fork
         push(1);
         send_pkt(1, 0, 0);
      join
      chk("t4_no_ovf", 256'(ovf), 256'(0));
      for (int i = 0; i < 16; i++) send_pkt($urandom_range(1, 3), 0, 0);
      tick();
      ones = 1;
      for (int i = 0; i < 16; i++) ones += int'(v[i]);
      chk("t4_pass", 256'(pc), 256'(ones));
      chk("t4_drop", 256'(dc), 256'(17 - ones));
      chk("t4_empty_nf", 256'(nf), 256'(0));

      // random ready, random verdicts, random packet lengths
      rdy_rand = 1;
      fork
         begin
            int pushed = 0;
            while (pushed < 40) begin
               if (mq.size() < 12 && $urandom_range(0, 1) == 1) begin
                  push(1'($urandom_range(0, 1)));
                  pushed++;
               end else tick();
            end
         end
         for (int k = 0; k < 40; k++) send_pkt($urandom_range(1, 5), 1, 0);
      join
      rdy_rand = 0;
      repeat (3) tick();
      chk("t5_total", 256'(pc + dc), 256'(ones + (17 - ones) + 40));

      // saturation and clear on the tlast beat
      force dut.pass_count = 32'hFFFF_FFFF;
      mpc = 32'hFFFF_FFFF;
      #2;
      release dut.pass_count;
      tick();
      push(1);
      send_pkt(2, 0, 0);
      tick();
      chk("t6_sat", 256'(pc), 256'(32'hFFFF_FFFF));
      push(1);
      send_pkt(2, 0, 1);
      tick();
      chk("t6_clr_pc", 256'(pc), 256'(0));
`ifdef FILTER_VERDICT_BYTE_COUNT_EN
      chk("t6_clr_bc", 256'(bc), 256'(0));
`endif

      // reset in the middle of a forwarded packet
      push(1);
      push(0);
      rand_beat(0);
      s_tvalid = 1;
      repeat (3) tick();
      rst = 1;
      repeat (2) tick();
      rst = 0;
      s_tvalid = 0;
      @(negedge clk);
      chk("t7_tvalid", 256'(m_tvalid), 256'(0));
      chk("t7_tready", 256'(s_tready), 256'(0));
      chk("t7_pc", 256'(pc), 256'(0));
      chk("t7_dc", 256'(dc), 256'(0));
      tick();
      // queue was emptied by reset: a new packet must stall
      rand_beat(1);
      s_tvalid = 1;
      repeat (3) begin
         @(negedge clk);
         chk("t7_stall", 256'(s_tready), 256'(0));
         tick();
      end
      s_tvalid = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
